// File: rtl/iter_product_if.sv
// Request/result bundle for iter_product: operands and control in, status and result out.
interface iter_product_if #(
  parameter int unsigned W  = 32,
  parameter int unsigned NW = 8
);
  logic          start;
  logic [1:0]    mode;
  logic [NW-1:0] n;
  logic [W-1:0]  x;
  logic          abort;
  logic          ready;
  logic          done;
  logic [W-1:0]  f;
  logic          ovf;

  modport master (output start, mode, n, x, abort, input  ready, done, f, ovf);
  modport slave  (input  start, mode, n, x, abort, output ready, done, f, ovf);
endinterface

// File: rtl/iter_product.sv
// Iterated product engine: n!, x^n or n!! built from repeated W-cycle shift-add multiplies.
module iter_product #(
  parameter int unsigned W  = 32,
  parameter int unsigned NW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  iter_product_if.slave  bus
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [1:0]  M_POW   = 2'b01;
  localparam logic [1:0]  M_DFACT = 2'b10;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MUL, S_UPDATE, S_DONE} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_mode;
  logic [NW-1:0] r_n, r_k;
  logic [W-1:0]  r_x, r_acc, r_fac, r_hi, r_lo, r_f;
  logic [CW-1:0] r_cnt;
  logic          r_ovf, r_ready, r_done;

  logic          w_busy, w_abort, w_mul_last;
  logic [NW:0]   w_n_inc;
  logic [NW-1:0] w_k_init;
  logic [W-1:0]  w_fac_init, w_fac_step;
  logic [W:0]    w_addend, w_sum;

  assign w_busy     = (r_state == S_LOAD) || (r_state == S_MUL) || (r_state == S_UPDATE);
  assign w_abort    = bus.abort && w_busy;
  assign w_mul_last = (r_cnt == CW'(W - 1));

  // Mode 11 falls through to the factorial paths since only 01 and 10 are decoded.
  assign w_n_inc    = {1'b0, r_n} + (NW+1)'(1);
  assign w_k_init   = (r_mode == M_DFACT) ? w_n_inc[NW:1] : r_n;
  assign w_fac_init = (r_mode == M_POW) ? r_x : W'(r_n);
  assign w_fac_step = (r_mode == M_POW)   ? r_fac :
                      (r_mode == M_DFACT) ? r_fac - W'(2) : r_fac - W'(1);

  // Right-shifting product: accumulator added into the high half when the multiplier LSB is set.
  assign w_addend = r_lo[0] ? {1'b0, r_acc} : '0;
  assign w_sum    = {1'b0, r_hi} + w_addend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start) w_next = S_LOAD;
      S_LOAD:   w_next = (w_k_init == '0) ? S_DONE : S_MUL;
      S_MUL:    if (w_mul_last) w_next = S_UPDATE;
      S_UPDATE: w_next = (r_k == NW'(1)) ? S_DONE : S_MUL;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode <= '0;
      r_n    <= '0;
      r_x    <= '0;
      r_k    <= '0;
      r_acc  <= '0;
      r_fac  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_cnt  <= '0;
      r_f    <= '0;
      r_ovf  <= 1'b0;
    end else if (w_abort) begin
      r_ovf <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (bus.start) begin
          r_mode <= bus.mode;
          r_n    <= bus.n;
          r_x    <= bus.x;
          r_ovf  <= 1'b0;
        end
        S_LOAD: begin
          r_acc <= W'(1);
          r_k   <= w_k_init;
          r_fac <= w_fac_init;
          r_hi  <= '0;
          r_lo  <= w_fac_init;
          r_cnt <= '0;
          if (w_k_init == '0) r_f <= W'(1);
        end
        S_MUL: begin
          {r_hi, r_lo} <= {w_sum, r_lo[W-1:1]};
          r_cnt        <= r_cnt + CW'(1);
        end
        S_UPDATE: begin
          r_acc <= r_lo;
          r_ovf <= r_ovf | (|r_hi);
          r_k   <= r_k - NW'(1);
          r_fac <= w_fac_step;
          r_hi  <= '0;
          r_lo  <= w_fac_step;
          r_cnt <= '0;
          if (r_k == NW'(1)) r_f <= r_lo;
        end
        default: ;
      endcase
    end
  end

  // Status flags registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_next == S_IDLE);
      r_done  <= (w_next == S_DONE);
    end
  end

  assign bus.ready = r_ready;
  assign bus.done  = r_done;
  assign bus.f     = r_f;
  assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_iter_product.sv
// Directed-vector bench for iter_product at W=32, NW=8 with hand-computed results and latencies.
module tb_iter_product;

  localparam int unsigned W     = 32;
  localparam int unsigned NW    = 8;
  localparam int          LIMIT = 2000;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  iter_product_if #(.W(W), .NW(NW)) bus ();

  iter_product #(.W(W), .NW(NW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [1:0] m, input logic [7:0] nn, input logic [31:0] xx);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    bus.n     = nn;
    bus.x     = xx;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Counts edges after the accept edge until done is seen; ready must stay low throughout.
  task automatic wait_done(output int lat);
    int bad;
    bad = 0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.ready) bad++;
    end while (!bus.done && lat < LIMIT);
    check("ready_low_while_busy", 64'(bad), 64'd0);
    check("done_seen", 64'(bus.done), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [1:0] m, input logic [7:0] nn,
                        input logic [31:0] xx, input logic [31:0] exp_f,
                        input logic exp_ovf, input int exp_lat);
    int lat;
    start_op(m, nn, xx);
    wait_done(lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_f"},   64'(bus.f), 64'(exp_f));
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(exp_ovf));
  endtask

  task automatic run_with_abort(input string tag, input logic [1:0] m, input logic [7:0] nn,
                                input logic [31:0] xx, input int abort_at,
                                input logic [31:0] prev_f, input int ovf_probe);
    int saw_done;
    saw_done = 0;
    start_op(m, nn, xx);
    for (int c = 1; c < abort_at; c++) begin
      @(negedge clk);
      if (bus.done) saw_done++;
      bus.start = (c == 10 || c == 20);
      bus.n     = 8'd2;
      if (ovf_probe != 0 && c == abort_at - 1)
        check({tag, "_ovf_mid_run"}, 64'(bus.ovf), 64'd1);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.abort = 1'b0;
    check({tag, "_no_done"}, 64'(saw_done + int'(bus.done)), 64'd0);
    check({tag, "_ready"},   64'(bus.ready), 64'd1);
    check({tag, "_f_kept"},  64'(bus.f), 64'(prev_f));
    check({tag, "_ovf_clr"}, 64'(bus.ovf), 64'd0);
    repeat (3) @(negedge clk);
    check({tag, "_still_idle"}, 64'({bus.ready, bus.done}), 64'b10);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.mode  = 2'b00;
    bus.n     = '0;
    bus.x     = '0;
    bus.abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.ready), 64'd1);
    check("rst_done",  64'(bus.done),  64'd0);
    check("rst_f",     64'(bus.f),     64'd0);
    check("rst_ovf",   64'(bus.ovf),   64'd0);
    rst_n = 1'b1;

    run_op("fact5", 2'b00, 8'd5, 32'd0, 32'd120, 1'b0, 166);
    @(negedge clk);
    check("fact5_done_pulse", 64'(bus.done), 64'd0);
    check("fact5_ready_back", 64'(bus.ready), 64'd1);
    check("fact5_f_hold",     64'(bus.f), 64'd120);

    run_op("fact13", 2'b00, 8'd13, 32'd0, 32'd1932053504, 1'b1, 430);
    repeat (2) @(negedge clk);
    check("fact13_ovf_hold", 64'(bus.ovf), 64'd1);

    start_op(2'b01, 8'd4, 32'd3);
    check("pow_ovf_clr_at_accept", 64'(bus.ovf), 64'd0);
    wait_done(lat);
    check("pow3_4_lat", 64'(lat), 64'd133);
    check("pow3_4_f",   64'(bus.f), 64'd81);

    run_op("pow0_0",  2'b01, 8'd0, 32'd0,       32'd1,   1'b0, 1);
    run_op("dfact7",  2'b10, 8'd7, 32'd0,       32'd105, 1'b0, 133);
    run_op("dfact0",  2'b10, 8'd0, 32'd0,       32'd1,   1'b0, 1);
    run_op("dfact6",  2'b10, 8'd6, 32'd0,       32'd48,  1'b0, 100);
    run_op("fact0",   2'b00, 8'd0, 32'd0,       32'd1,   1'b0, 1);
    run_op("mode11",  2'b11, 8'd4, 32'd9,       32'd24,  1'b0, 133);
    run_op("pow2e20", 2'b01, 8'd3, 32'h0010_0000, 32'd0, 1'b1, 100);
    run_op("fact1",   2'b00, 8'd1, 32'd0,       32'd1,   1'b0, 34);

    run_with_abort("abort_fact10", 2'b00, 8'd10, 32'd0, 50, 32'd1, 0);
    run_with_abort("abort_powovf", 2'b01, 8'd3, 32'h0010_0000, 80, 32'd1, 1);

    @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.mode  = 2'b00;
    bus.n     = 8'd3;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    wait_done(lat);
    check("start_abort_lat", 64'(lat), 64'd100);
    check("start_abort_f",   64'(bus.f), 64'd6);

    start_op(2'b00, 8'd10, 32'd0);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(bus.ready), 64'd1);
    check("midrst_f",     64'(bus.f),     64'd0);
    check("midrst_ovf",   64'(bus.ovf),   64'd0);
    check("midrst_done",  64'(bus.done),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_fact3", 2'b00, 8'd3, 32'd0, 32'd6, 1'b0, 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
